// File: rtl/cpu_clint_pkg.sv
// Shared definitions for the core-local interrupt block: bus word width,
// register offsets and the address decoder used by cpu_clint.
package cpu_clint_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [15:0] CLINT_MSIP_ADDR        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO_ADDR = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_ADDR = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO_ADDR    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_ADDR    = 16'hBFFC;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_TIME_LO,
        SEL_TIME_HI
    } reg_sel_e;

    // Word-address decode; byte-lane bits are dropped by the caller.
    function automatic reg_sel_e decode_addr(input logic [13:0] word_addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        if      (word_addr == CLINT_MSIP_ADDR[15:2])        sel = SEL_MSIP;
        else if (word_addr == CLINT_MTIMECMP_LO_ADDR[15:2]) sel = SEL_CMP_LO;
        else if (word_addr == CLINT_MTIMECMP_HI_ADDR[15:2]) sel = SEL_CMP_HI;
        else if (word_addr == CLINT_MTIME_LO_ADDR[15:2])    sel = SEL_TIME_LO;
        else if (word_addr == CLINT_MTIME_HI_ADDR[15:2])    sel = SEL_TIME_HI;
        return sel;
    endfunction

endpackage

// File: rtl/cpu_clint_sync2.sv
// Two-flop synchronizer for the asynchronous external interrupt line.
// Only instantiated when CLINT_EXT_SYNC_EN is defined.
module clint_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_pipe;

    // Shift the async input through two flops before anyone looks at it.
    always_ff @(posedge clk) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[0], d};
    end

    assign q = sync_pipe[1];

endmodule

// File: rtl/cpu_clint.sv
// Core-local interrupt block: mtime/mtimecmp timer, msip software interrupt
// and latched external interrupt, with a single-beat register bus.
// Optional feature: define CLINT_EXT_SYNC_EN to put ext_irq through a
// 2-flop synchronizer (adds 2 cycles of latency to meip).
module cpu_clint
    import cpu_clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_req,
    input  logic                  bus_we,
    input  logic [15:0]           bus_addr,
    input  logic [WORD_WIDTH-1:0] bus_wdata,
    output logic [WORD_WIDTH-1:0] bus_rdata,
    output logic                  bus_ack,
    input  logic                  ext_irq,
    input  logic                  external_int_clear,
    input  logic                  software_int_clear,
    input  logic                  timer_int_clear,
    output logic                  csr_mip_meip,
    output logic                  csr_mip_mtip,
    output logic                  csr_mip_msip
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]         presc;
    logic                  tick;
    logic [63:0]           mtime, mtime_nxt;
    logic [63:0]           mtimecmp, cmp_nxt;
    logic                  msip, msip_nxt;
    logic                  timer_masked, masked_nxt;
    logic                  meip_pend, meip_nxt;
    logic                  ext_armed, armed_nxt;
    logic                  mtip_q, mtip_nxt;
    logic                  tclr_q, sclr_q, eclr_q;
    logic                  tclr_rise, sclr_rise, eclr_rise;
    logic                  wr;
    logic                  ext_s;
    reg_sel_e              sel;
    logic [WORD_WIDTH-1:0] rd_mux;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^bus_addr[1:0];

    assign sel  = decode_addr(bus_addr[15:2]);
    assign wr   = bus_req & bus_we;
    assign tick = (presc == PW'(TICK_DIV - 1));

    // Clears are level handshakes held until the bit drops; only the
    // rising edge acts, so a held clear can never eat a new event.
    assign tclr_rise = timer_int_clear    & ~tclr_q;
    assign sclr_rise = software_int_clear & ~sclr_q;
    assign eclr_rise = external_int_clear & ~eclr_q;

`ifdef CLINT_EXT_SYNC_EN
    clint_sync2 u_ext_sync (
        .clk (clk),
        .rst (rst),
        .d   (ext_irq),
        .q   (ext_s)
    );
`else
    assign ext_s = ext_irq;
`endif

    // Next-state for all architectural state; pending bits are computed
    // from next-state values so every output is a plain flop.
    always_comb begin
        mtime_nxt  = mtime;
        cmp_nxt    = mtimecmp;
        msip_nxt   = msip;
        masked_nxt = timer_masked;
        meip_nxt   = meip_pend;
        armed_nxt  = ext_armed;

        // A bus write to either mtime half suppresses that cycle's tick.
        if (wr && sel == SEL_TIME_LO)      mtime_nxt[31:0]  = bus_wdata;
        else if (wr && sel == SEL_TIME_HI) mtime_nxt[63:32] = bus_wdata;
        else if (tick)                     mtime_nxt        = mtime + 64'd1;

        if (tclr_rise) masked_nxt = 1'b1;
        if (wr && sel == SEL_CMP_LO) begin
            cmp_nxt[31:0] = bus_wdata;
            masked_nxt    = 1'b0;
        end
        if (wr && sel == SEL_CMP_HI) begin
            cmp_nxt[63:32] = bus_wdata;
            masked_nxt     = 1'b0;
        end

        if (sclr_rise)              msip_nxt = 1'b0;
        if (wr && sel == SEL_MSIP)  msip_nxt = bus_wdata[0];

        // After a clear the line must be seen low before it can re-pend.
        if (eclr_rise) begin
            meip_nxt  = 1'b0;
            armed_nxt = 1'b0;
        end else begin
            if (!ext_s)              armed_nxt = 1'b1;
            if (ext_s && ext_armed)  meip_nxt  = 1'b1;
        end

        mtip_nxt = (mtime_nxt >= cmp_nxt) && !masked_nxt;
    end

    // Read mux; mtime reads see the value before this edge's increment.
    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_MSIP:    rd_mux = {{(WORD_WIDTH-1){1'b0}}, msip};
            SEL_CMP_LO:  rd_mux = mtimecmp[31:0];
            SEL_CMP_HI:  rd_mux = mtimecmp[63:32];
            SEL_TIME_LO: rd_mux = mtime[31:0];
            SEL_TIME_HI: rd_mux = mtime[63:32];
            default:     rd_mux = '0;
        endcase
    end

    // State registers, prescaler, clear-edge history and bus response.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc        <= '0;
            mtime        <= '0;
            mtimecmp     <= '1;
            msip         <= 1'b0;
            timer_masked <= 1'b0;
            meip_pend    <= 1'b0;
            ext_armed    <= 1'b1;
            mtip_q       <= 1'b0;
            tclr_q       <= 1'b0;
            sclr_q       <= 1'b0;
            eclr_q       <= 1'b0;
            bus_ack      <= 1'b0;
            bus_rdata    <= '0;
        end else begin
            presc        <= tick ? '0 : presc + PW'(1);
            mtime        <= mtime_nxt;
            mtimecmp     <= cmp_nxt;
            msip         <= msip_nxt;
            timer_masked <= masked_nxt;
            meip_pend    <= meip_nxt;
            ext_armed    <= armed_nxt;
            mtip_q       <= mtip_nxt;
            tclr_q       <= timer_int_clear;
            sclr_q       <= software_int_clear;
            eclr_q       <= external_int_clear;
            bus_ack      <= bus_req;
            bus_rdata    <= (bus_req && !bus_we) ? rd_mux : '0;
        end
    end

    assign csr_mip_mtip = mtip_q;
    assign csr_mip_msip = msip;
    assign csr_mip_meip = meip_pend;

endmodule
